// File: rtl/regbank_ctrl.sv
//------------------------------------------------------------------------------
// regbank_ctrl: round-robin access controller between two requesters and a
// register bank; issues one-hot word strobes and returns read data / ack.
//------------------------------------------------------------------------------
`default_nettype none

module regbank_ctrl #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 m0_req,
    input  logic                 m1_req,
    input  logic                 m0_we,
    input  logic                 m1_we,
    input  logic [AW-1:0]        m0_addr,
    input  logic [AW-1:0]        m1_addr,
    input  logic [DW-1:0]        m0_wdata,
    input  logic [DW-1:0]        m1_wdata,
    output logic                 m0_gnt,
    output logic                 m1_gnt,
    output logic                 m0_ack,
    output logic                 m1_ack,
    output logic                 m0_err,
    output logic                 m1_err,
    output logic [DW-1:0]        m0_rdata,
    output logic [DW-1:0]        m1_rdata,
    output logic [NREG-1:0]      reg_write,
    output logic [NREG-1:0]      reg_read,
    output logic [DW-1:0]        reg_wdata,
    input  logic [NREG*DW-1:0]   reg_ro
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            win_q, win_d;      // 0 = m0, 1 = m1
    logic            last_q, last_d;    // port granted most recently
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   ro_or;
    logic            in_access, in_done;
    logic [NREG-1:0] strobe;

    function automatic logic addr_bad(input logic [AW-1:0] a);
        return 32'(a) >= 32'(NREG);
    endfunction

    // Unselected words read as zero, so OR-ing all words yields the selected one.
    always_comb begin
        ro_or = '0;
        for (int i = 0; i < NREG; i++) begin
            ro_or = ro_or | reg_ro[i*DW +: DW];
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_d   = (m0_req && m1_req) ? ~last_q : m1_req;
                    last_d  = win_d;
                    we_d    = win_d ? m1_we    : m0_we;
                    addr_d  = win_d ? m1_addr  : m0_addr;
                    wdata_d = win_d ? m1_wdata : m0_wdata;
                    err_d   = addr_bad(addr_d);
                    rdata_d = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = (!we_q && !err_q) ? ro_or : '0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Qualifying with rstb kills a strobe whose ACCESS edge coincides with reset.
    assign in_access = rstb && (state_q == ACCESS);
    assign in_done   = rstb && (state_q == DONE);
    assign strobe    = (in_access && !err_q) ? (NREG'(1) << addr_q) : '0;

    assign reg_write = we_q ? strobe : '0;
    assign reg_read  = we_q ? '0 : strobe;
    assign reg_wdata = (in_access && !err_q) ? wdata_q : '0;

    assign m0_gnt   = in_access && !win_q;
    assign m1_gnt   = in_access &&  win_q;
    assign m0_ack   = in_done && !win_q;
    assign m1_ack   = in_done &&  win_q;
    assign m0_err   = m0_ack && err_q;
    assign m1_err   = m1_ack && err_q;
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_regbank_ctrl.sv
//------------------------------------------------------------------------------
// tb_regbank_ctrl: directed scenarios plus randomized two-port traffic against
// a transaction-level schedule model and a behavioural register bank.
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_regbank_ctrl;

    localparam int NREG = 8;
    localparam int AW   = 4;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata, reg_wdata;
    logic [NREG-1:0] reg_write, reg_read;
    logic [NREG*DW-1:0] reg_ro;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    regbank_ctrl #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstb(rstb),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_err(m0_err), .m1_err(m1_err), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .reg_write(reg_write), .reg_read(reg_read), .reg_wdata(reg_wdata), .reg_ro(reg_ro)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register bank with gated read outputs.
    logic [DW-1:0] bank [NREG] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            if (reg_write[i]) bank[i] <= reg_wdata;
    end
    always_comb begin
        reg_ro = '0;
        for (int i = 0; i < NREG; i++)
            reg_ro[i*DW +: DW] = reg_read[i] ? bank[i] : '0;
    end

    // Reference: each accepted request books its ACCESS and DONE cycles in a
    // small schedule; the model keeps its own copy of the bank contents.
    typedef struct packed {
        logic g0, g1, a0, a1, e0, e1;
        logic [DW-1:0]   r0, r1;
        logic [NREG-1:0] wr, rd;
        logic [DW-1:0]   wd;
        logic            cm;
        logic [AW-1:0]   ca;
        logic [DW-1:0]   cd;
    } exp_t;

    exp_t sched [4] = '{default: '0};
    logic [DW-1:0] mem [NREG] = '{default: '0};
    int free_c = 0;
    bit ptr = 1'b1;

    always @(negedge clk) begin : model
        exp_t e, acc, dn;
        bit w, we, bad;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int c;
        c = cyc;
        e = sched[c % 4];
        sched[c % 4] = '0;
        if (!rstb) e = '0;
        checks++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err} !== {e.g0, e.g1, e.a0, e.a1, e.e0, e.e1}
            || m0_rdata !== e.r0 || m1_rdata !== e.r1 || reg_write !== e.wr || reg_read !== e.rd
            || (e.wr != '0 && reg_wdata !== e.wd)) begin
            errors++;
            $display("FAIL model cyc=%0d got gnt=%b%b ack=%b%b err=%b%b rd=%h/%h wr=%h rs=%h wd=%h exp gnt=%b%b ack=%b%b err=%b%b rd=%h/%h wr=%h rs=%h wd=%h",
                     c, m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
                     reg_write, reg_read, reg_wdata, e.g0, e.g1, e.a0, e.a1, e.e0, e.e1,
                     e.r0, e.r1, e.wr, e.rd, e.wd);
        end
        if (!rstb) begin
            for (int i = 0; i < 4; i++) sched[i] = '0;
            free_c = c + 1;
            ptr = 1'b1;
        end else begin
            if (e.cm) mem[e.ca] = e.cd;
            if (c >= free_c && (m0_req || m1_req)) begin
                w   = (m0_req && m1_req) ? !ptr : m1_req;
                ptr = w;
                we  = w ? m1_we : m0_we;
                a   = w ? m1_addr : m0_addr;
                d   = w ? m1_wdata : m0_wdata;
                bad = int'(a) >= NREG;
                acc = '0;
                dn  = '0;
                acc.g0 = !w;
                acc.g1 = w;
                if (!bad) begin
                    if (we) begin
                        acc.wr = NREG'(1) << a;
                        acc.wd = d;
                        acc.cm = 1'b1;
                        acc.ca = a;
                        acc.cd = d;
                    end else begin
                        acc.rd = NREG'(1) << a;
                    end
                end
                dn.a0 = !w;
                dn.a1 = w;
                dn.e0 = !w && bad;
                dn.e1 = w && bad;
                if (!w) dn.r0 = (!we && !bad) ? mem[a[2:0]] : '0;
                else    dn.r1 = (!we && !bad) ? mem[a[2:0]] : '0;
                sched[(c + 1) % 4] = acc;
                sched[(c + 2) % 4] = dn;
                free_c = c + 3;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic set_port(input bit p, input bit rq, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p) begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
        else    begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    // One complete request: raise req, wait for gnt, drop req, collect the ack.
    task automatic access(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output logic er,
                          output logic [NREG-1:0] stb, output int gc);
        bit got;
        got = 1'b0;
        rd = '0; er = 1'b0; stb = '0; gc = -1;
        @(posedge clk); #1;
        set_port(p, 1'b1, we, a, d);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (p ? m1_gnt : m0_gnt) begin
                got = 1'b1;
                gc  = cyc;
                stb = we ? reg_write : reg_read;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout port=%0d got no gnt expected gnt within 60 cycles", p);
            set_port(p, 1'b0, 1'b0, '0, '0);
            return;
        end
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check($sformatf("ack_seen_p%0d", p), p ? m1_ack : m0_ack, 1);
        er = p ? m1_err : m0_err;
        rd = p ? m1_rdata : m0_rdata;
    endtask

    task automatic rand_port(input bit p, input int n);
        logic [DW-1:0] rd;
        logic er;
        logic [NREG-1:0] stb;
        int gc;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            access(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)), DW'($urandom),
                   rd, er, stb, gc);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] rd0, rd1;
        logic er0, er1, q;
        logic [NREG-1:0] s0, s1;
        int g0, g1, c1, c2;
        int ga [3];
        int gb [3];
        bit ok, got;

        // Reset held with both ports requesting; m0 must win first after release.
        q = 1'b0;
        fork
            access(1'b0, 1'b0, 4'd0, 8'h00, rd0, er0, s0, g0);
            access(1'b1, 1'b0, 4'd1, 8'h00, rd1, er1, s1, g1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    q = q | m0_gnt | m1_gnt | m0_ack | m1_ack | (|reg_write) | (|reg_read);
                end
                check("rst_quiet", q, 0);
                @(posedge clk); #1;
                rstb = 1'b1;
            end
        join
        check("first_gnt_m0", (g0 < g1) ? 1 : 0, 1);
        check("second_gnt_spacing", g1 - g0, 3);

        // Write then read back the same word.
        access(1'b0, 1'b1, 4'd2, 8'hA5, rd0, er0, s0, g0);
        check("wr_strobe", s0, 8'h04);
        access(1'b0, 1'b0, 4'd2, 8'h00, rd0, er0, s0, g0);
        check("rd_strobe", s0, 8'h04);
        check("rd_data", rd0, 8'hA5);
        check("rd_err", er0, 0);

        // Continuous contention: m0 was granted last, so m1 leads.
        fork
            for (int k = 0; k < 3; k++) access(1'b0, 1'b1, AW'(k), DW'(8'h10 + k), rd0, er0, s0, ga[k]);
            for (int k = 0; k < 3; k++) access(1'b1, 1'b0, AW'(k + 4), 8'h00, rd1, er1, s1, gb[k]);
        join
        check("contend_first_m1", ga[0] - gb[0], 3);
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (ga[k] != gb[k] + 3) ok = 1'b0;
            if (k < 2 && gb[k + 1] != ga[k] + 3) ok = 1'b0;
        end
        check("contend_alternate", ok, 1);

        // Out-of-range read from m1.
        access(1'b1, 1'b0, 4'd9, 8'h00, rd1, er1, s1, g1);
        check("err_no_strobe", s1, 0);
        check("err_flag", er1, 1);
        check("err_rdata", rd1, 0);

        // Reset landing on the ACCESS cycle of a write.
        access(1'b0, 1'b1, 4'd5, 8'h11, rd0, er0, s0, g0);
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C);
        @(posedge clk); #1;
        rstb = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_mid_strobe", {m0_gnt, reg_write}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_noack", m0_ack, 0);
        @(posedge clk); #1;
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_bank_kept", bank[5], 8'h11);
        access(1'b0, 1'b0, 4'd5, 8'h00, rd0, er0, s0, g0);
        check("rst_mid_readback", rd0, 8'h11);

        // m1 holds req past its gnt: a second access follows 3 cycles later.
        @(posedge clk); #1;
        set_port(1'b1, 1'b1, 1'b0, 4'd1, 8'h00);
        c1 = -100; c2 = -100;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (m1_gnt) begin
                if (c1 < 0) c1 = cyc;
                else begin c2 = cyc; got = 1'b1; end
            end
        end
        @(posedge clk); #1;
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        check("hold_regrant_spacing", c2 - c1, 3);

        // Randomized two-port traffic, checked cycle by cycle by the model.
        repeat (3) @(posedge clk);
        fork
            rand_port(1'b0, 40);
            rand_port(1'b1, 40);
        join
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
